ccsds123_frame_ctrl: RTL

//  Frame sequencer in front of the CCSDS-123 predictor/encoder core. Accepts raw samples in
//  BIP order (z fastest, then x, then y), tags each with its image coordinates and edge flags,
//  and forwards it through a registered stream. Once per image it arms on start, drains the

---
 rtl/ccsds123_pkg.sv | 30 +++
 rtl/ccsds123_coord_cnt.sv | 68 ++++++
 rtl/ccsds123_frame_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ccsds123_pkg.sv
// Shared types and helpers for the CCSDS-123 frame sequencer.
//  - frame_state_e : sequencer FSM states
//  - cnt_width()   : counter width for values 0..n-1 (never narrower than 1 bit)
//  - Def*          : default image geometry and matching coordinate widths
package ccsds123_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StFlush
  } frame_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

  localparam int unsigned DefNx = 4;
  localparam int unsigned DefNy = 4;
  localparam int unsigned DefNz = 16;
  localparam int unsigned DefXw = cnt_width(DefNx);
  localparam int unsigned DefYw = cnt_width(DefNy);
  localparam int unsigned DefZw = cnt_width(DefNz);

endpackage

// File: rtl/ccsds123_coord_cnt.sv
// Nested BIP-order coordinate counters: z fastest, then x, then y.
// Ports:
//  clk, areset      clock, asynchronous active-high reset
//  advance          step to the next sample position
//  z                current band index
//  first_line       y == 0
//  first_in_line    x == 0
//  last_in_line     x == NX-1
//  last             current position is the final sample of the frame
// The counters wrap back to (0,0,0) when the final sample advances.
module ccsds123_coord_cnt
  import ccsds123_pkg::*;
#(
  parameter int unsigned NX = 4,
  parameter int unsigned NY = 4,
  parameter int unsigned NZ = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     advance,
  output logic [cnt_width(NZ)-1:0] z,
  output logic                     first_line,
  output logic                     first_in_line,
  output logic                     last_in_line,
  output logic                     last
);

  localparam int unsigned Xw = cnt_width(NX);
  localparam int unsigned Yw = cnt_width(NY);
  localparam int unsigned Zw = cnt_width(NZ);

  logic [Xw-1:0] x_q;
  logic [Yw-1:0] y_q;
  logic [Zw-1:0] z_q;

  logic z_wrap, x_wrap, y_wrap;

  assign z_wrap = (z_q == Zw'(NZ - 1));
  assign x_wrap = (x_q == Xw'(NX - 1));
  assign y_wrap = (y_q == Yw'(NY - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (advance) begin
      if (!z_wrap) begin
        z_q <= z_q + Zw'(1);
      end else begin
        z_q <= '0;
        if (!x_wrap) begin
          x_q <= x_q + Xw'(1);
        end else begin
          x_q <= '0;
          y_q <= y_wrap ? '0 : y_q + Yw'(1);
        end
      end
    end
  end

  assign z             = z_q;
  assign first_line    = (y_q == '0);
  assign first_in_line = (x_q == '0);
  assign last_in_line  = x_wrap;
  assign last          = z_wrap && x_wrap && y_wrap;

endmodule

// File: rtl/ccsds123_frame_ctrl.sv
// Frame sequencer in front of the CCSDS-123 predictor/encoder core.
// Tags BIP-ordered samples with coordinates/edge flags and forwards them through a one-deep
// registered stream. Per frame: arm on start, accept NX*NY*NZ samples, wait for the output
// register to empty plus DRAIN idle cycles, then pulse flush/done for one cycle.
// Ports:
//  clk, areset                      clock, asynchronous active-high reset
//  start                            arm one frame (ignored unless idle)
//  s_axis_tdata/tvalid/tready/tlast input sample stream
//  m_tdata/m_tvalid/m_tready        registered output stream to the core
//  m_z, m_first_line, m_first_in_line, m_last_in_line, m_last  tags for m_tdata
//  flush, done                      one-cycle end-of-frame pulse
//  busy                             frame in progress
//  err_tlast                        sticky tlast mismatch
// Optional feature: define CCSDS123_FRAME_CTRL_TLAST_CHECK_EN to compare s_axis_tlast with the
// computed frame end; otherwise s_axis_tlast is ignored and err_tlast is tied low.
module ccsds123_frame_ctrl
  import ccsds123_pkg::*;
#(
  parameter int unsigned NX    = 4,
  parameter int unsigned NY    = 4,
  parameter int unsigned NZ    = 16,
  parameter int unsigned D     = 16,
  parameter int unsigned DRAIN = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [D-1:0]             s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [D-1:0]             m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [cnt_width(NZ)-1:0] m_z,
  output logic                     m_first_line,
  output logic                     m_first_in_line,
  output logic                     m_last_in_line,
  output logic                     m_last,
  output logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic                     err_tlast
);

  localparam int unsigned Zw = cnt_width(NZ);
  localparam int unsigned Cw = cnt_width(DRAIN);

  frame_state_e state_q;
  logic [Cw-1:0] drain_cnt_q;
  logic          flush_q, done_q, busy_q;

  logic [D-1:0]  m_tdata_q;
  logic          m_tvalid_q;
  logic [Zw-1:0] m_z_q;
  logic          m_first_line_q, m_first_in_line_q, m_last_in_line_q, m_last_q;

  logic          accept;
  logic [Zw-1:0] cnt_z;
  logic          cnt_first_line, cnt_first_in_line, cnt_last_in_line, cnt_last;

  assign s_axis_tready = (state_q == StRun) && (!m_tvalid_q || m_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  ccsds123_coord_cnt #(
    .NX (NX),
    .NY (NY),
    .NZ (NZ)
  ) u_coord_cnt (
    .clk           (clk),
    .areset        (areset),
    .advance       (accept),
    .z             (cnt_z),
    .first_line    (cnt_first_line),
    .first_in_line (cnt_first_in_line),
    .last_in_line  (cnt_last_in_line),
    .last          (cnt_last)
  );

  // Sequencer. The drain counter only runs once the output register is empty, so DRAIN idle
  // cycles are guaranteed after the last output handshake regardless of core back-pressure.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= StIdle;
      drain_cnt_q <= '0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (accept && cnt_last) begin
            state_q     <= StDrain;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          if (m_tvalid_q) begin
            drain_cnt_q <= '0;
          end else if (drain_cnt_q == Cw'(DRAIN - 1)) begin
            state_q     <= StFlush;
            drain_cnt_q <= '0;
            flush_q     <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + Cw'(1);
          end
        end
        StFlush: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // One-deep output register; data and tags are left untouched when the slot empties.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_tdata_q         <= '0;
      m_tvalid_q        <= 1'b0;
      m_z_q             <= '0;
      m_first_line_q    <= 1'b0;
      m_first_in_line_q <= 1'b0;
      m_last_in_line_q  <= 1'b0;
      m_last_q          <= 1'b0;
    end else if (accept) begin
      m_tdata_q         <= s_axis_tdata;
      m_tvalid_q        <= 1'b1;
      m_z_q             <= cnt_z;
      m_first_line_q    <= cnt_first_line;
      m_first_in_line_q <= cnt_first_in_line;
      m_last_in_line_q  <= cnt_last_in_line;
      m_last_q          <= cnt_last;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

`ifdef CCSDS123_FRAME_CTRL_TLAST_CHECK_EN
  logic err_tlast_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      err_tlast_q <= 1'b0;
    end else if ((state_q == StIdle) && start) begin
      err_tlast_q <= 1'b0;
    end else if (accept && (s_axis_tlast != cnt_last)) begin
      err_tlast_q <= 1'b1;
    end
  end

  assign err_tlast = err_tlast_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign err_tlast    = 1'b0;
`endif

  assign m_tdata         = m_tdata_q;
  assign m_tvalid        = m_tvalid_q;
  assign m_z             = m_z_q;
  assign m_first_line    = m_first_line_q;
  assign m_first_in_line = m_first_in_line_q;
  assign m_last_in_line  = m_last_in_line_q;
  assign m_last          = m_last_q;
  assign flush           = flush_q;
  assign done            = done_q;
  assign busy            = busy_q;

endmodule
